// File: rtl/qracc_stream_driver_pkg.sv
// qracc_stream_driver_pkg: state, segment-length types and helpers for the QRAcc stream driver.
package qracc_stream_driver_pkg;
    localparam int LEN_W = 32;

    typedef enum logic [2:0] {
        S_IDLE, S_WEIGHTS, S_ACTS, S_SCALERS, S_BIAS, S_WAIT, S_READ, S_DONE
    } stream_state_t;

    typedef struct packed {
        logic [LEN_W-1:0] weight;
        logic [LEN_W-1:0] act;
        logic [LEN_W-1:0] scaler;
        logic [LEN_W-1:0] bias;
        logic [LEN_W-1:0] out;
    } stream_lengths_t;

    function automatic logic [LEN_W-1:0] seg_len(input stream_state_t s, input stream_lengths_t l);
        return s == S_WEIGHTS ? l.weight :
               s == S_ACTS    ? l.act    :
               s == S_SCALERS ? l.scaler :
               s == S_BIAS    ? l.bias   :
               s == S_READ    ? l.out    : '0;
    endfunction

    function automatic logic is_write(input stream_state_t s);
        return s inside {S_WEIGHTS, S_ACTS, S_SCALERS, S_BIAS};
    endfunction
endpackage

// File: rtl/qracc_stream_driver_if.sv
// qracc_stream_driver_if: QRAcc data-port handshake between the stream driver and the accelerator.
interface qracc_stream_driver_if #(
    parameter int DATA_W = 32
);
    logic              bus_valid;
    logic              bus_wen;
    logic [DATA_W-1:0] bus_data_out;
    logic              bus_ready;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rd_data_valid;

    modport master(output bus_valid, bus_wen, bus_data_out,
                   input bus_ready, bus_rd_data, bus_rd_data_valid);
    modport slave(input bus_valid, bus_wen, bus_data_out,
                  output bus_ready, bus_rd_data, bus_rd_data_valid);
endinterface

// File: rtl/qracc_stream_prefetch_fifo.sv
// qracc_stream_prefetch_fifo: small synchronous FIFO holding prefetched source words.
module qracc_stream_prefetch_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic              do_push, do_pop;

    assign empty   = count == '0;
    assign full    = int'(count) == DEPTH;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/qracc_stream_driver.sv
// qracc_stream_driver: streams one layer's segments from a source SRAM into the QRAcc data port and
// drains the output fmap into a sink SRAM; define QRACC_STREAM_PERF_EN for stall/busy cycle counters.
module qracc_stream_driver
    import qracc_stream_driver_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int SRC_AW     = 12,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              clear,
    input  logic [CNT_W-1:0]  n_weight_words,
    input  logic [CNT_W-1:0]  n_act_words,
    input  logic [CNT_W-1:0]  n_scaler_words,
    input  logic [CNT_W-1:0]  n_bias_words,
    input  logic [CNT_W-1:0]  n_out_words,
    input  logic [SRC_AW-1:0] src_base,
    input  logic [SRC_AW-1:0] sink_base,
    output logic              src_rd_en,
    output logic [SRC_AW-1:0] src_addr,
    input  logic [DATA_W-1:0] src_rd_data,
    output logic              sink_wr_en,
    output logic [SRC_AW-1:0] sink_addr,
    output logic [DATA_W-1:0] sink_wr_data,
    qracc_stream_driver_if.master bus,
    output logic              busy,
    output logic              done,
    output logic [2:0]        seg_o
`ifdef QRACC_STREAM_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_total_cycles
`endif
);
    stream_state_t   state;
    stream_lengths_t lens;
    logic [CNT_W-1:0]  cnt, fetched;
    logic [SRC_AW-1:0] sink_base_r;
    logic              inflight;
    logic [DATA_W-1:0] f_head;
    logic              f_full, f_empty;
    logic [$clog2(FIFO_DEPTH+1)-1:0] f_count;
    logic [LEN_W-1:0]  len;
    logic              wr_seg, xfer, rd_word, seg_end;

    assign wr_seg  = is_write(state);
    assign len     = seg_len(state, lens);
    assign xfer    = wr_seg && !f_empty && bus.bus_ready;
    assign rd_word = state == S_READ && bus.bus_rd_data_valid;
    assign seg_end = (wr_seg || state == S_READ) &&
                     (LEN_W'(cnt) == len || ((xfer || rd_word) && LEN_W'(cnt) + 1 == len));

    // A word popped this cycle frees its slot, which keeps a depth-2 FIFO streaming at 1 word/cycle.
    assign src_rd_en = wr_seg && !clear && LEN_W'(fetched) < len && (!f_full || xfer) &&
                       int'(f_count) + int'(inflight) - int'(xfer) < FIFO_DEPTH;

    assign bus.bus_valid    = wr_seg ? !f_empty : state == S_READ;
    assign bus.bus_wen      = wr_seg;
    assign bus.bus_data_out = f_head;
    assign sink_wr_en       = rd_word;
    assign sink_addr        = sink_base_r + SRC_AW'(cnt);
    assign sink_wr_data     = rd_word ? bus.bus_rd_data : '0;
    assign busy             = state != S_IDLE;
    assign done             = state == S_DONE;
    assign seg_o            = state;

    qracc_stream_prefetch_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .nrst(nrst), .clr(clear), .push(inflight), .pop(xfer), .din(src_rd_data),
        .head(f_head), .full(f_full), .empty(f_empty), .count(f_count)
    );

    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            state       <= S_IDLE;
            lens        <= '0;
            cnt         <= '0;
            fetched     <= '0;
            src_addr    <= '0;
            sink_base_r <= '0;
            inflight    <= 1'b0;
        end else if (clear) begin
            state    <= S_IDLE;
            cnt      <= '0;
            fetched  <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= src_rd_en;
            if (src_rd_en) begin
                src_addr <= src_addr + 1'b1;
                fetched  <= fetched + 1'b1;
            end
            if (xfer || rd_word) cnt <= cnt + 1'b1;
            if (state == S_IDLE && start) begin
                state       <= S_WEIGHTS;
                lens        <= '{weight: LEN_W'(n_weight_words), act: LEN_W'(n_act_words),
                                 scaler: LEN_W'(n_scaler_words), bias: LEN_W'(n_bias_words),
                                 out: LEN_W'(n_out_words)};
                src_addr    <= src_base;
                sink_base_r <= sink_base;
            end else if (state == S_WAIT && bus.bus_rd_data_valid) state <= S_READ;
            else if (state == S_DONE) state <= S_IDLE;
            else if (seg_end) begin
                state   <= stream_state_t'(state + 3'd1);
                cnt     <= '0;
                fetched <= '0;
            end
        end

`ifdef QRACC_STREAM_PERF_EN
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            perf_stall_cycles <= '0;
            perf_total_cycles <= '0;
        end else if (clear || (state == S_IDLE && start)) begin
            perf_stall_cycles <= '0;
            perf_total_cycles <= '0;
        end else begin
            if (wr_seg && !f_empty && !bus.bus_ready && !(&perf_stall_cycles))
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            if (busy && !(&perf_total_cycles)) perf_total_cycles <= perf_total_cycles + 1'b1;
        end
`endif
endmodule
